// File: rtl/chan_scan_capture.sv
// Time-division scanner over NCH single-bit channels with a skip mask.
// Each completed sweep is assembled into a snapshot with a one-cycle valid pulse.
module chan_scan_capture #(
    parameter  int NCH   = 4,
    localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [NCH-1:0]   din,
    output logic [SEL_W-1:0] sel,
    output logic             data,
    output logic [NCH-1:0]   onehot,
    output logic [NCH-1:0]   snap,
    output logic             snap_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [NCH-1:0]   onehot_n, snap_n, shadow, shadow_n, amask, amask_n, cap;
    logic             snap_valid_n, amode, amode_n;
    logic [SEL_W:0]   above;

    function automatic logic [SEL_W-1:0] lowest_bit(input logic [NCH-1:0] m);
        lowest_bit = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) lowest_bit = SEL_W'(i);
    endfunction

    // Returns {found, index} of the nearest set bit strictly above s.
    function automatic logic [SEL_W:0] next_above(input logic [NCH-1:0] m,
                                                  input logic [SEL_W-1:0] s);
        next_above = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i] && (i > int'(s))) next_above = {1'b1, SEL_W'(i)};
    endfunction

    assign data  = din[sel];
    assign busy  = (state == SCAN);
    assign above = next_above(amask, sel);

    always_comb begin
        state_n      = state;
        sel_n        = sel;
        onehot_n     = '0;
        snap_n       = snap;
        snap_valid_n = 1'b0;
        shadow_n     = shadow;
        amask_n      = amask;
        amode_n      = amode;
        cap          = '0;

        case (state)
            IDLE: begin
                if (en && (ch_mask != '0) && (!mode || start)) begin
                    state_n  = SCAN;
                    amask_n  = ch_mask;
                    amode_n  = mode;
                    shadow_n = '0;
                    sel_n    = lowest_bit(ch_mask);
                end
            end
            SCAN: begin
                if (!en && above[SEL_W]) begin
                    state_n = IDLE;
                end else begin
                    shadow_n[sel] = din[sel];
                    onehot_n      = din[sel] ? (NCH'(1) << sel) : '0;
                    if (above[SEL_W]) begin
                        sel_n = above[SEL_W-1:0];
                    end else begin
                        // Last visited channel: publish the sweep, even if en just fell.
                        cap          = shadow;
                        cap[sel]     = din[sel];
                        snap_n       = cap & amask;
                        snap_valid_n = 1'b1;
                        sel_n        = lowest_bit(amask);
                        if (!amode && en && !mode && (ch_mask != '0)) begin
                            amask_n  = ch_mask;
                            amode_n  = mode;
                            shadow_n = '0;
                            sel_n    = lowest_bit(ch_mask);
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            onehot     <= '0;
            snap       <= '0;
            snap_valid <= 1'b0;
            shadow     <= '0;
            amask      <= '0;
            amode      <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            onehot     <= onehot_n;
            snap       <= snap_n;
            snap_valid <= snap_valid_n;
            shadow     <= shadow_n;
            amask      <= amask_n;
            amode      <= amode_n;
        end
    end

endmodule

// File: tb/tb_chan_scan_capture.sv
// Directed bench for chan_scan_capture: table of per-edge vectors on a 4-channel
// instance plus hand-written sequences for async reset, late abort and NCH=5.
module tb_chan_scan_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, mode = 1'b0, start = 1'b0;
    logic [3:0] mask4 = '0, din4 = '0;
    logic [4:0] mask5 = '0, din5 = '0;

    logic [1:0] sel4;
    logic       data4, valid4, busy4;
    logic [3:0] oh4, snap4;
    logic [2:0] sel5;
    logic       data5, valid5, busy5;
    logic [4:0] oh5, snap5;

    int tests = 0;
    int fails = 0;

    chan_scan_capture #(.NCH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
        .ch_mask(mask4), .din(din4), .sel(sel4), .data(data4), .onehot(oh4),
        .snap(snap4), .snap_valid(valid4), .busy(busy4)
    );

    chan_scan_capture #(.NCH(5)) dut5 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
        .ch_mask(mask5), .din(din5), .sel(sel5), .data(data5), .onehot(oh5),
        .snap(snap5), .snap_valid(valid5), .busy(busy5)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       en;
        bit       mode;
        bit       start;
        bit [3:0] mask;
        bit [3:0] din;
        bit [1:0] sel;
        bit [3:0] oh;
        bit       valid;
        bit [3:0] snap;
        bit       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // rst en md st mask din -> sel oh valid snap busy
        // Continuous, all channels, din 0101
        vecs.push_back('{1, 1, 0, 0, 4'b1111, 4'b0101, 2'd0, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd1, 4'b0001, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd2, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd3, 4'b0100, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd0, 4'b0000, 1, 4'b0101, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd1, 4'b0001, 0, 4'b0101, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd2, 4'b0000, 0, 4'b0101, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd3, 4'b0100, 0, 4'b0101, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0101, 2'd0, 4'b0000, 1, 4'b0101, 1});
        // Skip mask 1010, then mask 0001 mid-sweep (M=1 afterwards)
        vecs.push_back('{1, 1, 0, 0, 4'b1010, 4'b1111, 2'd1, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1010, 4'b1111, 2'd3, 4'b0010, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1010, 4'b1111, 2'd1, 4'b1000, 1, 4'b1010, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b0001, 4'b1111, 2'd3, 4'b0010, 0, 4'b1010, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b0001, 4'b1111, 2'd0, 4'b1000, 1, 4'b1010, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b0001, 4'b1111, 2'd0, 4'b0001, 1, 4'b0001, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b0001, 4'b1111, 2'd0, 4'b0001, 1, 4'b0001, 1});
        // Single-shot, din 1001, repeated start while busy, then start with empty mask
        vecs.push_back('{1, 1, 1, 1, 4'b1111, 4'b1001, 2'd0, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 1, 1, 4'b1111, 4'b1001, 2'd1, 4'b0001, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 1, 0, 4'b1111, 4'b1001, 2'd2, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 1, 0, 4'b1111, 4'b1001, 2'd3, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 1, 0, 4'b1111, 4'b1001, 2'd0, 4'b1000, 1, 4'b1001, 0});
        vecs.push_back('{0, 1, 1, 0, 4'b1111, 4'b1001, 2'd0, 4'b0000, 0, 4'b1001, 0});
        vecs.push_back('{0, 1, 1, 1, 4'b0000, 4'b1001, 2'd0, 4'b0000, 0, 4'b1001, 0});
        vecs.push_back('{0, 1, 1, 1, 4'b0000, 4'b1001, 2'd0, 4'b0000, 0, 4'b1001, 0});
        // Abort after two samples of the second sweep, previous snap 0110
        vecs.push_back('{1, 1, 0, 0, 4'b1111, 4'b0110, 2'd0, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd1, 4'b0000, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd2, 4'b0010, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd3, 4'b0100, 0, 4'b0000, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd0, 4'b0000, 1, 4'b0110, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd1, 4'b0000, 0, 4'b0110, 1});
        vecs.push_back('{0, 1, 0, 0, 4'b1111, 4'b0110, 2'd2, 4'b0010, 0, 4'b0110, 1});
        vecs.push_back('{0, 0, 0, 0, 4'b1111, 4'b1111, 2'd2, 4'b0000, 0, 4'b0110, 0});
        vecs.push_back('{0, 0, 0, 0, 4'b1111, 4'b1111, 2'd2, 4'b0000, 0, 4'b0110, 0});

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            en    = vecs[i].en;
            mode  = vecs[i].mode;
            start = vecs[i].start;
            mask4 = vecs[i].mask;
            din4  = vecs[i].din;
            tick();
            check("sel", i, 32'(sel4), 32'(vecs[i].sel));
            check("onehot", i, 32'(oh4), 32'(vecs[i].oh));
            check("snap_valid", i, 32'(valid4), 32'(vecs[i].valid));
            check("snap", i, 32'(snap4), 32'(vecs[i].snap));
            check("busy", i, 32'(busy4), 32'(vecs[i].busy));
        end

        // Asynchronous reset mid-scan, checked before the next rising edge
        do_reset();
        en = 1'b1; mode = 1'b0; mask4 = 4'b1111; din4 = 4'b1111;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        check("areset_sel", 0, 32'(sel4), 32'd0);
        check("areset_onehot", 0, 32'(oh4), 32'd0);
        check("areset_snap", 0, 32'(snap4), 32'd0);
        check("areset_valid", 0, 32'(valid4), 32'd0);
        check("areset_busy", 0, 32'(busy4), 32'd0);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        check("post_reset_idle", 0, 32'(busy4), 32'd0);

        // en falls together with the last-channel sample: sweep still completes
        do_reset();
        en = 1'b1; mode = 1'b0; mask4 = 4'b0011; din4 = 4'b0011;
        tick();
        tick();
        check("late_abort_sel", 0, 32'(sel4), 32'd1);
        en = 1'b0;
        tick();
        check("late_abort_valid", 0, 32'(valid4), 32'd1);
        check("late_abort_snap", 0, 32'(snap4), 32'b0011);
        check("late_abort_onehot", 0, 32'(oh4), 32'b0010);
        check("late_abort_busy", 0, 32'(busy4), 32'd0);
        tick();
        check("late_abort_valid_drop", 0, 32'(valid4), 32'd0);

        // NCH=5, non-power-of-two wrap
        do_reset();
        mask4 = '0;
        en = 1'b1; mode = 1'b0; mask5 = 5'b11111; din5 = 5'b10110;
        for (int k = 0; k <= 11; k++) begin
            tick();
            check("n5_sel", k, 32'(sel5), 32'(k % 5));
            check("n5_data", k, 32'(data5), 32'(din5[k % 5]));
            check("n5_valid", k, 32'(valid5), 32'((k > 0) && (k % 5 == 0)));
            if (k >= 5) check("n5_snap", k, 32'(snap5), 32'b10110);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
